// File: rtl/axi4_if.sv
// AXI4 bus bundle with master and slave views.
// aclk/aresetn are carried for slaves that need them; masters take their own clock.
interface axi4_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned ID_WIDTH   = 4,
    parameter int unsigned USER_WIDTH = 4
) (
    input logic aclk,
    input logic aresetn
);
    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

    logic [ID_WIDTH-1:0]   aw_id;
    logic [ADDR_WIDTH-1:0] aw_addr;
    logic [7:0]            aw_len;
    logic [2:0]            aw_size;
    logic [1:0]            aw_burst;
    logic                  aw_lock;
    logic [3:0]            aw_cache;
    logic [2:0]            aw_prot;
    logic [3:0]            aw_qos;
    logic [3:0]            aw_region;
    logic [USER_WIDTH-1:0] aw_user;
    logic                  aw_valid;
    logic                  aw_ready;

    logic [DATA_WIDTH-1:0] w_data;
    logic [STRB_WIDTH-1:0] w_strb;
    logic                  w_last;
    logic [USER_WIDTH-1:0] w_user;
    logic                  w_valid;
    logic                  w_ready;

    logic [ID_WIDTH-1:0]   b_id;
    logic [1:0]            b_resp;
    logic [USER_WIDTH-1:0] b_user;
    logic                  b_valid;
    logic                  b_ready;

    logic [ID_WIDTH-1:0]   ar_id;
    logic [ADDR_WIDTH-1:0] ar_addr;
    logic [7:0]            ar_len;
    logic [2:0]            ar_size;
    logic [1:0]            ar_burst;
    logic                  ar_lock;
    logic [3:0]            ar_cache;
    logic [2:0]            ar_prot;
    logic [3:0]            ar_qos;
    logic [3:0]            ar_region;
    logic [USER_WIDTH-1:0] ar_user;
    logic                  ar_valid;
    logic                  ar_ready;

    logic [ID_WIDTH-1:0]   r_id;
    logic [DATA_WIDTH-1:0] r_data;
    logic [1:0]            r_resp;
    logic                  r_last;
    logic [USER_WIDTH-1:0] r_user;
    logic                  r_valid;
    logic                  r_ready;

    // Single-ID master: returned IDs and user bits are not consumed.
    modport master (
        output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache,
               aw_prot, aw_qos, aw_region, aw_user, aw_valid,
        input  aw_ready,
        output w_data, w_strb, w_last, w_user, w_valid,
        input  w_ready,
        input  b_resp, b_valid,
        output b_ready,
        output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache,
               ar_prot, ar_qos, ar_region, ar_user, ar_valid,
        input  ar_ready,
        input  r_data, r_resp, r_last, r_valid,
        output r_ready
    );

    modport slave (
        input  aclk, aresetn,
        input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache,
               aw_prot, aw_qos, aw_region, aw_user, aw_valid,
        output aw_ready,
        input  w_data, w_strb, w_last, w_user, w_valid,
        output w_ready,
        output b_id, b_resp, b_user, b_valid,
        input  b_ready,
        input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache,
               ar_prot, ar_qos, ar_region, ar_user, ar_valid,
        output ar_ready,
        output r_id, r_data, r_resp, r_last, r_user, r_valid,
        input  r_ready
    );
endinterface

// File: rtl/axi4_burst_master.sv
// Single-command AXI4 burst initiator: one read or write burst in flight, done pulse + response.
// Define AXI4_BURST_MASTER_4K_CHECK_EN to reject INCR bursts that cross a 4KB boundary.
module axi4_burst_master #(
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter int unsigned AXI_DATA_WIDTH = 64,
    parameter int unsigned AXI_ID_WIDTH   = 4,
    parameter int unsigned AXI_USER_WIDTH = 4,
    parameter int unsigned AXI_ID         = 0
) (
    input  logic                        aclk,
    input  logic                        areset,
    input  logic                        cmd_valid_i,
    output logic                        cmd_ready_o,
    input  logic                        cmd_write_i,
    input  logic [AXI_ADDR_WIDTH-1:0]   cmd_addr_i,
    input  logic [7:0]                  cmd_len_i,
    input  logic [1:0]                  cmd_burst_i,
    input  logic                        wdat_valid_i,
    output logic                        wdat_ready_o,
    input  logic [AXI_DATA_WIDTH-1:0]   wdat_i,
    input  logic [AXI_DATA_WIDTH/8-1:0] wstrb_i,
    output logic                        rdat_valid_o,
    input  logic                        rdat_ready_i,
    output logic [AXI_DATA_WIDTH-1:0]   rdat_o,
    output logic                        rdat_last_o,
    output logic                        done_o,
    output logic [1:0]                  resp_o,
    axi4_if.master                      axi4
);
    localparam int unsigned STRB_WIDTH = AXI_DATA_WIDTH / 8;
    localparam int unsigned SIZE       = $clog2(STRB_WIDTH);
    localparam logic [AXI_ADDR_WIDTH-1:0] ALIGN_MASK = ~AXI_ADDR_WIDTH'(STRB_WIDTH - 1);
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_AR,
        S_RDATA,
        S_AW,
        S_WDATA,
        S_WRESP,
        S_DONE
    } state_e;

    state_e                    state_q, state_d;
    logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]                len_q, len_d;
    logic [1:0]                burst_q, burst_d;
    logic [7:0]                cnt_q, cnt_d;
    logic [1:0]                resp_q, resp_d;

    logic [AXI_ADDR_WIDTH-1:0] cmd_addr_aligned_c;
    logic                      wrap_bad_c;
    logic                      cross_4k_c;
    logic                      reject_c;
    logic                      rd_phase_c;
    logic                      wr_phase_c;
    logic                      w_last_c;

    assign cmd_addr_aligned_c = cmd_addr_i & ALIGN_MASK;
    assign wrap_bad_c = (cmd_burst_i == BURST_WRAP) &&
                        !(cmd_len_i inside {8'd1, 8'd3, 8'd7, 8'd15});

`ifdef AXI4_BURST_MASTER_4K_CHECK_EN
    // End offset within the 4KB page; anything past 4096 spills into the next page.
    logic [16:0] end_off_c;
    assign end_off_c  = 17'(cmd_addr_aligned_c[11:0]) + ((17'(cmd_len_i) + 17'd1) << SIZE);
    assign cross_4k_c = (cmd_burst_i == BURST_INCR) && (end_off_c > 17'd4096);
`else
    assign cross_4k_c = 1'b0;
`endif

    assign reject_c = wrap_bad_c || cross_4k_c;

    // State and latched command.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            len_q   <= '0;
            burst_q <= '0;
            cnt_q   <= '0;
            resp_q  <= RESP_OKAY;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            burst_q <= burst_d;
            cnt_q   <= cnt_d;
            resp_q  <= resp_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        len_d   = len_q;
        burst_d = burst_q;
        cnt_d   = cnt_q;
        resp_d  = resp_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid_i) begin
                    addr_d  = cmd_addr_aligned_c;
                    len_d   = cmd_len_i;
                    burst_d = cmd_burst_i;
                    cnt_d   = '0;
                    resp_d  = RESP_OKAY;
                    if (reject_c) begin
                        state_d = S_DONE;
                        resp_d  = RESP_SLVERR;
                    end else if (cmd_write_i) begin
                        state_d = S_AW;
                    end else begin
                        state_d = S_AR;
                    end
                end
            end
            S_AR: begin
                if (axi4.ar_ready) begin
                    state_d = S_RDATA;
                    cnt_d   = '0;
                end
            end
            S_RDATA: begin
                if (axi4.r_valid && rdat_ready_i) begin
                    cnt_d = cnt_q + 8'd1;
                    if (axi4.r_resp > resp_q) begin
                        resp_d = axi4.r_resp;
                    end
                    if (axi4.r_last) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_AW: begin
                if (axi4.aw_ready) begin
                    state_d = S_WDATA;
                    cnt_d   = '0;
                end
            end
            S_WDATA: begin
                if (wdat_valid_i && axi4.w_ready) begin
                    cnt_d = cnt_q + 8'd1;
                    if (w_last_c) begin
                        state_d = S_WRESP;
                    end
                end
            end
            S_WRESP: begin
                if (axi4.b_valid) begin
                    resp_d  = axi4.b_resp;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign rd_phase_c = (state_q == S_RDATA);
    assign wr_phase_c = (state_q == S_WDATA);
    assign w_last_c   = (cnt_q == len_q);

    // Local command/completion side; ready is held low while reset is asserted.
    assign cmd_ready_o = (state_q == S_IDLE) && !areset;
    assign done_o      = (state_q == S_DONE);
    assign resp_o      = done_o ? resp_q : RESP_OKAY;

    // Read data is passed straight through; the local consumer only throttles.
    assign rdat_valid_o = rd_phase_c && axi4.r_valid;
    assign rdat_o       = rd_phase_c ? axi4.r_data : '0;
    assign rdat_last_o  = rd_phase_c && axi4.r_last;
    assign axi4.r_ready = rd_phase_c && rdat_ready_i;

    assign axi4.ar_valid  = (state_q == S_AR);
    assign axi4.ar_id     = AXI_ID_WIDTH'(AXI_ID);
    assign axi4.ar_addr   = addr_q;
    assign axi4.ar_len    = len_q;
    assign axi4.ar_size   = 3'(SIZE);
    assign axi4.ar_burst  = burst_q;
    assign axi4.ar_lock   = 1'b0;
    assign axi4.ar_cache  = 4'd0;
    assign axi4.ar_prot   = 3'd0;
    assign axi4.ar_qos    = 4'd0;
    assign axi4.ar_region = 4'd0;
    assign axi4.ar_user   = '0;

    assign axi4.aw_valid  = (state_q == S_AW);
    assign axi4.aw_id     = AXI_ID_WIDTH'(AXI_ID);
    assign axi4.aw_addr   = addr_q;
    assign axi4.aw_len    = len_q;
    assign axi4.aw_size   = 3'(SIZE);
    assign axi4.aw_burst  = burst_q;
    assign axi4.aw_lock   = 1'b0;
    assign axi4.aw_cache  = 4'd0;
    assign axi4.aw_prot   = 3'd0;
    assign axi4.aw_qos    = 4'd0;
    assign axi4.aw_region = 4'd0;
    assign axi4.aw_user   = '0;

    // W channel only opens once the AW handshake has moved us to WDATA.
    assign axi4.w_valid  = wr_phase_c && wdat_valid_i;
    assign axi4.w_data   = wr_phase_c ? wdat_i : '0;
    assign axi4.w_strb   = wr_phase_c ? wstrb_i : '0;
    assign axi4.w_last   = wr_phase_c && w_last_c;
    assign axi4.w_user   = '0;
    assign wdat_ready_o  = wr_phase_c && axi4.w_ready;

    assign axi4.b_ready  = (state_q == S_WRESP);

endmodule

// File: tb/tb_axi4_burst_master.sv
// Randomized bench for axi4_burst_master: behavioural AXI slave driven from tasks, with a
// transaction-level model of expected beats, responses, rejections and completion timing.
`timescale 1ns/1ps
module tb_axi4_burst_master;
    localparam int unsigned AW    = 32;
    localparam int unsigned DW    = 64;
    localparam int unsigned IW    = 4;
    localparam int unsigned UW    = 4;
    localparam int unsigned ID    = 5;
    localparam int unsigned BYTES = DW / 8;

    logic            clk = 1'b0;
    logic            rst;
    logic            cmd_valid;
    logic            cmd_ready;
    logic            cmd_write;
    logic [AW-1:0]   cmd_addr;
    logic [7:0]      cmd_len;
    logic [1:0]      cmd_burst;
    logic            wdat_valid;
    logic            wdat_ready;
    logic [DW-1:0]   wdat;
    logic [BYTES-1:0] wstrb;
    logic            rdat_valid;
    logic            rdat_ready;
    logic [DW-1:0]   rdat;
    logic            rdat_last;
    logic            done;
    logic [1:0]      resp;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    axi4_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .USER_WIDTH(UW)) axi (
        .aclk(clk), .aresetn(!rst)
    );

    axi4_burst_master #(
        .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .AXI_ID_WIDTH(IW),
        .AXI_USER_WIDTH(UW), .AXI_ID(ID)
    ) dut (
        .aclk(clk), .areset(rst),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_write_i(cmd_write),
        .cmd_addr_i(cmd_addr), .cmd_len_i(cmd_len), .cmd_burst_i(cmd_burst),
        .wdat_valid_i(wdat_valid), .wdat_ready_o(wdat_ready), .wdat_i(wdat), .wstrb_i(wstrb),
        .rdat_valid_o(rdat_valid), .rdat_ready_i(rdat_ready), .rdat_o(rdat),
        .rdat_last_o(rdat_last), .done_o(done), .resp_o(resp),
        .axi4(axi)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [1:0] pick_resp();
        int unsigned r;
        r = $urandom_range(0, 9);
        if (r < 7) return 2'b00;
        if (r < 9) return 2'b10;
        return 2'b11;
    endfunction

    // Rejection rules: illegal WRAP length, plus 4KB crossing when the check is built in.
    function automatic bit expect_reject(input logic [31:0] addr, input logic [7:0] len,
                                         input logic [1:0] burst);
        if (burst == 2'b10 && !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15))
            return 1'b1;
`ifdef AXI4_BURST_MASTER_4K_CHECK_EN
        begin
            int unsigned off;
            int unsigned span;
            off  = (int'(addr[11:0]) / BYTES) * BYTES;
            span = (int'(len) + 1) * BYTES;
            if (burst == 2'b01 && off + span > 4096) return 1'b1;
        end
`endif
        return 1'b0;
    endfunction

    task automatic set_idle();
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0; cmd_burst = '0;
        wdat_valid = 1'b0; wdat = '0; wstrb = '0; rdat_ready = 1'b0;
        axi.aw_ready = 1'b0; axi.w_ready = 1'b0; axi.ar_ready = 1'b0;
        axi.b_valid = 1'b0; axi.b_resp = 2'b00; axi.b_id = '0; axi.b_user = '0;
        axi.r_valid = 1'b0; axi.r_data = '0; axi.r_resp = 2'b00; axi.r_last = 1'b0;
        axi.r_id = '0; axi.r_user = '0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        set_idle();
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Present one command; returns at the negedge following acceptance.
    task automatic issue_cmd(input logic wr, input logic [31:0] addr, input logic [7:0] len,
                             input logic [1:0] burst);
        @(negedge clk);
        cmd_write = wr; cmd_addr = addr; cmd_len = len; cmd_burst = burst; cmd_valid = 1'b1;
        #1;
        check("cmd_ready", 64'(cmd_ready), 64'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // Called while done is expected high: the pulse must be one cycle, then IDLE.
    task automatic finish_txn();
        @(negedge clk);
        #1;
        check("done_pulse_end", 64'(done), 64'd0);
        check("back_to_idle", 64'(cmd_ready), 64'd1);
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                           input int bp_mode, input bit stall, input bit det);
        logic [DW-1:0] data_q[$];
        logic [1:0]    rr_q[$];
        logic [1:0]    exp_resp;
        logic [31:0]   exp_addr;
        int            beats, k, cyc;
        bit            hs;
        beats    = int'(len) + 1;
        exp_resp = 2'b00;
        exp_addr = addr & ~32'(BYTES - 1);
        for (int i = 0; i < beats; i++) begin
            data_q.push_back(det ? 64'h00A0 + 64'(i) : {$urandom, $urandom});
            rr_q.push_back(det ? 2'b00 : pick_resp());
            if (rr_q[i] > exp_resp) exp_resp = rr_q[i];
        end
        issue_cmd(1'b0, addr, len, burst);
        #1;
        if (expect_reject(addr, len, burst)) begin
            check("rd_rej_arvalid", 64'(axi.ar_valid), 64'd0);
            check("rd_rej_done", 64'(done), 64'd1);
            check("rd_rej_resp", 64'(resp), 64'd2);
            finish_txn();
            return;
        end
        check("ar_valid", 64'(axi.ar_valid), 64'd1);
        check("ar_addr", 64'(axi.ar_addr), 64'(exp_addr));
        check("ar_len", 64'(axi.ar_len), 64'(len));
        check("ar_burst", 64'(axi.ar_burst), 64'(burst));
        check("ar_size", 64'(axi.ar_size), 64'd3);
        check("ar_id", 64'(axi.ar_id), 64'(ID));
        check("rd_no_aw", 64'(axi.aw_valid), 64'd0);
        hs = 1'b0; cyc = 0;
        while (!hs && cyc < 64) begin
            axi.ar_ready = stall ? ($urandom_range(0, 2) == 0) : 1'b1;
            #1;
            check("ar_hold", 64'(axi.ar_addr), 64'(exp_addr));
            hs = axi.ar_valid && axi.ar_ready;
            @(negedge clk);
            axi.ar_ready = 1'b0;
            cyc++;
        end
        if (!hs) begin
            check("ar_timeout", 64'd0, 64'd1);
            apply_reset();
            return;
        end
        k = 0; cyc = 0;
        while (k < beats && cyc < 4000) begin
            axi.r_valid = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
            axi.r_data  = data_q[k];
            axi.r_resp  = rr_q[k];
            axi.r_last  = (k == beats - 1);
            case (bp_mode)
                0:       rdat_ready = 1'b1;
                1:       rdat_ready = (cyc % 2 == 0);
                default: rdat_ready = ($urandom_range(0, 1) == 1);
            endcase
            #1;
            check("r_ready", 64'(axi.r_ready), 64'(rdat_ready));
            check("rdat_valid", 64'(rdat_valid), 64'(axi.r_valid));
            if (axi.r_valid && rdat_ready) begin
                check("rdat", 64'(rdat), 64'(data_q[k]));
                check("rdat_last", 64'(rdat_last), 64'(k == beats - 1));
                k++;
            end
            @(negedge clk);
            cyc++;
        end
        axi.r_valid = 1'b0; axi.r_last = 1'b0; rdat_ready = 1'b0;
        if (k < beats) begin
            check("r_timeout", 64'(k), 64'(beats));
            apply_reset();
            return;
        end
        #1;
        check("rd_done", 64'(done), 64'd1);
        check("rd_resp", 64'(resp), 64'(exp_resp));
        finish_txn();
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                            input logic [1:0] bresp, input bit stall);
        logic [DW-1:0]    data_q[$];
        logic [BYTES-1:0] strb_q[$];
        logic [31:0]      exp_addr;
        int               beats, k, cyc;
        bit               hs;
        beats    = int'(len) + 1;
        exp_addr = addr & ~32'(BYTES - 1);
        for (int i = 0; i < beats; i++) begin
            data_q.push_back({$urandom, $urandom});
            strb_q.push_back(BYTES'($urandom));
        end
        issue_cmd(1'b1, addr, len, burst);
        #1;
        if (expect_reject(addr, len, burst)) begin
            check("wr_rej_awvalid", 64'(axi.aw_valid), 64'd0);
            check("wr_rej_wvalid", 64'(axi.w_valid), 64'd0);
            check("wr_rej_done", 64'(done), 64'd1);
            check("wr_rej_resp", 64'(resp), 64'd2);
            finish_txn();
            return;
        end
        check("aw_valid", 64'(axi.aw_valid), 64'd1);
        check("aw_addr", 64'(axi.aw_addr), 64'(exp_addr));
        check("aw_len", 64'(axi.aw_len), 64'(len));
        check("aw_burst", 64'(axi.aw_burst), 64'(burst));
        check("aw_size", 64'(axi.aw_size), 64'd3);
        check("aw_id", 64'(axi.aw_id), 64'(ID));
        check("wr_no_ar", 64'(axi.ar_valid), 64'd0);
        hs = 1'b0; cyc = 0;
        while (!hs && cyc < 64) begin
            axi.aw_ready = stall ? ($urandom_range(0, 2) == 0) : 1'b1;
            wdat_valid = 1'b1; wdat = data_q[0]; wstrb = strb_q[0]; axi.w_ready = 1'b1;
            #1;
            check("w_before_aw", 64'(axi.w_valid), 64'd0);
            check("aw_hold", 64'(axi.aw_addr), 64'(exp_addr));
            hs = axi.aw_valid && axi.aw_ready;
            @(negedge clk);
            axi.aw_ready = 1'b0;
            cyc++;
        end
        if (!hs) begin
            check("aw_timeout", 64'd0, 64'd1);
            apply_reset();
            return;
        end
        k = 0; cyc = 0;
        while (k < beats && cyc < 4000) begin
            wdat_valid  = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
            wdat        = data_q[k];
            wstrb       = strb_q[k];
            axi.w_ready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
            #1;
            if (cyc == 0 && !stall) check("w_first_beat", 64'(axi.w_valid), 64'd1);
            check("w_valid", 64'(axi.w_valid), 64'(wdat_valid));
            check("wdat_ready", 64'(wdat_ready), 64'(axi.w_ready));
            if (axi.w_valid) check("w_last", 64'(axi.w_last), 64'(k == beats - 1));
            if (axi.w_valid && axi.w_ready) begin
                check("w_data", 64'(axi.w_data), 64'(data_q[k]));
                check("w_strb", 64'(axi.w_strb), 64'(strb_q[k]));
                k++;
            end
            @(negedge clk);
            cyc++;
        end
        wdat_valid = 1'b0; axi.w_ready = 1'b0;
        if (k < beats) begin
            check("w_timeout", 64'(k), 64'(beats));
            apply_reset();
            return;
        end
        hs = 1'b0; cyc = 0;
        while (!hs && cyc < 64) begin
            axi.b_valid = stall ? ($urandom_range(0, 2) == 0) : 1'b1;
            axi.b_resp  = bresp;
            #1;
            check("b_ready", 64'(axi.b_ready), 64'd1);
            hs = axi.b_valid;
            @(negedge clk);
            axi.b_valid = 1'b0;
            cyc++;
        end
        if (!hs) begin
            check("b_timeout", 64'd0, 64'd1);
            apply_reset();
            return;
        end
        #1;
        check("wr_done", 64'(done), 64'd1);
        check("wr_resp", 64'(resp), 64'(bresp));
        finish_txn();
    endtask

    // Reset after two of four write beats: everything drops at once and nothing resumes.
    task automatic reset_mid_write();
        issue_cmd(1'b1, 32'h0000_3000, 8'd3, 2'b01);
        axi.aw_ready = 1'b1; wdat_valid = 1'b1; wdat = 64'h1111_2222_3333_4444;
        wstrb = '1; axi.w_ready = 1'b0;
        @(negedge clk);
        axi.aw_ready = 1'b0; axi.w_ready = 1'b1;
        #1;
        check("mid_w_valid", 64'(axi.w_valid), 64'd1);
        @(negedge clk);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("rst_w_valid", 64'(axi.w_valid), 64'd0);
        check("rst_w_last", 64'(axi.w_last), 64'd0);
        check("rst_wdat_ready", 64'(wdat_ready), 64'd0);
        check("rst_aw_valid", 64'(axi.aw_valid), 64'd0);
        check("rst_ar_valid", 64'(axi.ar_valid), 64'd0);
        check("rst_b_ready", 64'(axi.b_ready), 64'd0);
        check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_resp", 64'(resp), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_ready", 64'(cmd_ready), 64'd1);
        for (int i = 0; i < 3; i++) begin
            check("post_rst_no_w", 64'(axi.w_valid), 64'd0);
            check("post_rst_no_wrdy", 64'(wdat_ready), 64'd0);
            @(negedge clk);
            #1;
        end
        set_idle();
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        logic [7:0]  l;
        logic [1:0]  b;
        rst = 1'b1;
        set_idle();
        #2;
        check("reset_cmd_ready", 64'(cmd_ready), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_resp", 64'(resp), 64'd0);
        check("reset_ar_valid", 64'(axi.ar_valid), 64'd0);
        check("reset_aw_valid", 64'(axi.aw_valid), 64'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("idle_cmd_ready", 64'(cmd_ready), 64'd1);
        check("idle_rdat_valid", 64'(rdat_valid), 64'd0);

        do_read(32'h0000_1000, 8'd3, 2'b01, 0, 1'b0, 1'b1);
        do_write(32'h0000_2008, 8'd1, 2'b01, 2'b10, 1'b0);
        do_read(32'h0000_3000, 8'd7, 2'b01, 1, 1'b0, 1'b0);
        do_read(32'h0000_0040, 8'd2, 2'b10, 0, 1'b0, 1'b0);
        do_read(32'h0000_0018, 8'd3, 2'b10, 0, 1'b0, 1'b0);
        reset_mid_write();
        do_write(32'h0000_0FF8, 8'd1, 2'b01, 2'b00, 1'b0);
        do_write(32'h0000_0000, 8'd255, 2'b01, 2'b00, 1'b0);
        do_read(32'h0000_5003, 8'd4, 2'b00, 2, 1'b1, 1'b0);

        for (int t = 0; t < 30; t++) begin
            a = $urandom;
            b = 2'($urandom_range(0, 2));
            l = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(0, 63)) : 8'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) do_write(a, l, b, pick_resp(), 1'b1);
            else                           do_read(a, l, b, 2, 1'b1, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/axi4_burst_master.md
Name: axi4_burst_master

Overview:
- AXI4 initiator that converts a single-command local request into one AXI4 read or write burst.
- Counterpart of the AXI4 SRAM slave; used by DMA, boot-loader and test engines to drive SRAM blocks over the axi4_if bus.
- One transaction in flight at a time.
- Write data enters on a local valid/ready stream; read data leaves on a local valid/ready stream.
- Completion is reported with a one-cycle done pulse and a response code.

Parameters:
AXI_ADDR_WIDTH, 32, address width
AXI_DATA_WIDTH, 64, data width (power of 2, >= 32)
AXI_ID_WIDTH, 4, ID width
AXI_USER_WIDTH, 4, user width; all user outputs are driven to 0
AXI_ID, 0, constant ID driven on aw_id/ar_id

Ports:
aclk  input  1  clock
areset  input  1  asynchronous active-high reset
cmd_valid_i  input  1  command valid
cmd_ready_o  output  1  command accepted when valid&ready
cmd_write_i  input  1  1=write burst, 0=read burst
cmd_addr_i  input  AXI_ADDR_WIDTH  start byte address
cmd_len_i  input  8  beats-1 (AxLEN)
cmd_burst_i  input  2  00 FIXED, 01 INCR, 10 WRAP
wdat_valid_i  input  1  write beat valid
wdat_ready_o  output  1  write beat consumed
wdat_i  input  AXI_DATA_WIDTH  write data
wstrb_i  input  AXI_DATA_WIDTH/8  write byte strobes
rdat_valid_o  output  1  read beat valid
rdat_ready_i  input  1  read beat consumer ready
rdat_o  output  AXI_DATA_WIDTH  read data
rdat_last_o  output  1  final read beat
done_o  output  1  one-cycle pulse at end of transaction
resp_o  output  2  response for done_o (00 OKAY, 10 SLVERR, 11 DECERR)
axi4  interface  axi4_if.master  AXI4 bus; the interface's aclk/aresetn are not used by this block

Behaviour:
- Reset (areset=1, asynchronous) or any reset mid-transaction:
  - State returns to IDLE.
  - All valid/ready/last/done outputs are 0; resp_o=00; beat counter=0; latched command=0.
  - No beats are replayed after release.
- States: IDLE, AR, RDATA, AW, WDATA, WRESP, DONE.
- IDLE:
  - cmd_ready_o=1.
  - On cmd_valid_i, latch the command; low LOG2(DATA_WIDTH/8) address bits are forced to 0.
  - Next state: AW if cmd_write_i, else AR.
  - WRAP with len not in {1,3,7,15} goes directly to DONE with resp=10; no bus activity.
- AR:
  - ar_valid=1, ar_addr/len/burst from the latch, ar_size=LOG2(DATA_WIDTH/8), ar_id=AXI_ID, other Ax fields 0.
  - Request fields are held stable until ar_ready, then go to RDATA.
- RDATA:
  - Combinational pass-through: rdat_valid_o=r_valid, r_ready=rdat_ready_i, rdat_o=r_data, rdat_last_o=r_last.
  - On each handshake the counter increments, and a sticky response takes the maximum r_resp seen.
  - Handshake with r_last goes to DONE.
  - The local side applies backpressure only; no beat is ever dropped.
- AW:
  - aw_valid with the same field rules as AR.
  - On aw_ready, go to WDATA with counter=0.
  - W is never driven before AW completes.
- WDATA:
  - w_valid=wdat_valid_i, wdat_ready_o=w_ready, w_data=wdat_i, w_strb=wstrb_i.
  - w_last=(counter==len).
  - Counter increments on each w handshake.
  - Handshake with w_last goes to WRESP.
- WRESP:
  - b_ready=1.
  - On b_valid, latch b_resp and go to DONE.
- DONE:
  - done_o=1 with resp_o for exactly one cycle, then IDLE.
  - cmd_ready_o=0 in DONE, so back-to-back commands have a minimum one-cycle gap.
- Latency (zero-wait slave):
  - Read: cmd accept -> ar_valid next cycle.
  - Write: cmd accept -> aw_valid next cycle; first w beat the cycle after aw handshake.
  - done_o one cycle after the last r handshake (read) or the b handshake (write).
- Counter is 8 bits. Beats = len+1, max 256. No wrap-around; len=255 produces w_last on count 255.
- Addresses are issued exactly as latched. WRAP/FIXED address sequencing is the slave's responsibility.
- Ignored inputs:
  - r_valid outside RDATA and b_valid outside WRESP are ignored; r_ready/b_ready are 0 there.
  - wdat_valid_i outside WDATA is not acknowledged.

Optional Feature:
- Macro AXI4_BURST_MASTER_4K_CHECK_EN.
- Defined: a command whose burst crosses a 4KB boundary is rejected without bus activity; goes IDLE -> DONE with resp=10.
  - INCR crosses when addr[11:0] + ((len+1)<<LOG2(DATA_WIDTH/8)) > 4096.
  - FIXED never crosses.
- Not defined: no check; the command is issued as given.

Test Plan:
- Read INCR, addr 0x1000, len 3, slave returns 0xA0..0xA3 OKAY -> ar_addr=0x1000, ar_len=3, ar_size=3; rdat_o sequence A0,A1,A2,A3; rdat_last_o on beat 4; done_o with resp 00.
- Write INCR, addr 0x2008, len 1, slave b_resp=10 -> w_last on beat 2 only; done_o resp 10.
- Backpressure: read len 7, rdat_ready_i toggling every cycle -> r_ready follows; exactly 8 beats delivered in order; no loss.
- WRAP, len 2 -> no ar/aw_valid; done_o resp 10 one cycle after accept. WRAP, len 3 at addr 0x18 -> ar_addr=0x18, ar_burst=10.
- Reset asserted during WDATA after beat 2 of 4 -> all outputs 0 same cycle; after release, cmd_ready_o=1 and no w_valid.
- Macro defined: INCR, addr 0x0FF8, len 1 -> rejected, resp 10. Macro undefined: same command -> aw_valid issued with addr 0x0FF8.
